mastermind_core: RTL and testbench

MASTERMIND_CORE -- requirements
Module: mastermind_core

---
 rtl/mastermind_core.sv | 220 ++++++++++++++++++++++
 tb/tb_mastermind_core.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_core.sv
// mastermind_core: code-breaking game engine with peg editor and min-count scorer.
// Optional per-turn guess/score history: define MASTERMIND_HISTORY_EN.
module mastermind_core #(
   parameter int NUM_PEGS  = 4,
   parameter int COLOR_W   = 3,
   parameter int MAX_TURNS = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_PEGS*COLOR_W-1:0]        code_in,
   input  logic                               code_load,
   input  logic                               btn_left,
   input  logic                               btn_right,
   input  logic                               btn_up,
   input  logic                               btn_down,
   input  logic                               btn_select,
   output logic [NUM_PEGS*COLOR_W-1:0]        guess_out,
   output logic [$clog2(NUM_PEGS)-1:0]        cursor,
   output logic [$clog2(MAX_TURNS)-1:0]       turn,
   output logic [$clog2(NUM_PEGS+1)-1:0]      score_exact,
   output logic [$clog2(NUM_PEGS+1)-1:0]      score_partial,
   output logic                               score_valid,
   output logic                               busy,
   output logic                               game_over,
   output logic                               win
`ifdef MASTERMIND_HISTORY_EN
   ,
   input  logic [$clog2(MAX_TURNS)-1:0]       hist_idx,
   output logic [NUM_PEGS*COLOR_W-1:0]        hist_guess,
   output logic [$clog2(NUM_PEGS+1)-1:0]      hist_exact,
   output logic [$clog2(NUM_PEGS+1)-1:0]      hist_partial
`endif
);

   localparam int CUR_W  = $clog2(NUM_PEGS);
   localparam int TURN_W = $clog2(MAX_TURNS);
   localparam int SC_W   = $clog2(NUM_PEGS + 1);
   localparam int CODE_W = NUM_PEGS * COLOR_W;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ENTRY  = 3'd1;
   localparam logic [2:0] S_EXACT  = 3'd2;
   localparam logic [2:0] S_COLOR  = 3'd3;
   localparam logic [2:0] S_REPORT = 3'd4;
   localparam logic [2:0] S_WON    = 3'd5;
   localparam logic [2:0] S_LOST   = 3'd6;

   logic [2:0]         state;
   logic [COLOR_W-1:0] code_q  [NUM_PEGS];
   logic [COLOR_W-1:0] guess_q [NUM_PEGS];
   logic [COLOR_W-1:0] col_q;
   logic [SC_W-1:0]    exact_q;
   logic [SC_W-1:0]    acc_q;
   logic [SC_W-1:0]    exact_now;
   logic [SC_W-1:0]    cnt_code;
   logic [SC_W-1:0]    cnt_guess;
   logic [SC_W-1:0]    acc_nxt;
   logic               act_sel;
   logic               act_left;
   logic               act_right;
   logic               act_up;
   logic               act_down;
   logic               load_ok;
   logic               col_last;
   logic               report_wr;

   assign busy      = (state == S_EXACT) || (state == S_COLOR);
   assign game_over = (state == S_WON) || (state == S_LOST);
   assign win       = (state == S_WON);
   assign load_ok   = code_load && !busy;
   assign col_last  = (col_q == {COLOR_W{1'b1}});
   assign report_wr = (state == S_COLOR) && col_last;

   // Resolve button priority into a one-hot set before decoding
   always_comb begin
      act_sel   = btn_select;
      act_left  = btn_left  && !btn_select;
      act_right = btn_right && !btn_select && !btn_left;
      act_up    = btn_up    && !btn_select && !btn_left && !btn_right;
      act_down  = btn_down  && !btn_select && !btn_left && !btn_right
                  && !btn_up;
   end

   always_comb begin
      exact_now = '0;
      cnt_code  = '0;
      cnt_guess = '0;
      for (int i = 0; i < NUM_PEGS; i++) begin
         if (code_q[i] == guess_q[i])
            exact_now = exact_now + SC_W'(1);
         if (code_q[i] == col_q)
            cnt_code = cnt_code + SC_W'(1);
         if (guess_q[i] == col_q)
            cnt_guess = cnt_guess + SC_W'(1);
      end
      acc_nxt = acc_q + ((cnt_code < cnt_guess) ? cnt_code : cnt_guess);
   end

   always_comb begin
      guess_out = '0;
      for (int i = 0; i < NUM_PEGS; i++)
         guess_out[i*COLOR_W +: COLOR_W] = guess_q[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cursor        <= '0;
         turn          <= '0;
         score_exact   <= '0;
         score_partial <= '0;
         score_valid   <= 1'b0;
         exact_q       <= '0;
         acc_q         <= '0;
         col_q         <= '0;
         for (int i = 0; i < NUM_PEGS; i++) begin
            code_q[i]  <= '0;
            guess_q[i] <= '0;
         end
      end else begin
         score_valid <= 1'b0;
         if (load_ok) begin
            state         <= S_ENTRY;
            cursor        <= '0;
            turn          <= '0;
            score_exact   <= '0;
            score_partial <= '0;
            for (int i = 0; i < NUM_PEGS; i++) begin
               code_q[i]  <= code_in[i*COLOR_W +: COLOR_W];
               guess_q[i] <= '0;
            end
         end else begin
            case (state)
               S_ENTRY: begin
                  unique case (1'b1)
                     act_sel:
                        state <= S_EXACT;
                     act_left:
                        cursor <= (cursor == '0) ?
                                  CUR_W'(NUM_PEGS - 1) : cursor - CUR_W'(1);
                     act_right:
                        cursor <= (cursor == CUR_W'(NUM_PEGS - 1)) ?
                                  '0 : cursor + CUR_W'(1);
                     act_up:
                        guess_q[cursor] <= guess_q[cursor] + COLOR_W'(1);
                     act_down:
                        guess_q[cursor] <= guess_q[cursor] - COLOR_W'(1);
                     default: ;
                  endcase
               end
               S_EXACT: begin
                  exact_q <= exact_now;
                  acc_q   <= '0;
                  col_q   <= '0;
                  state   <= S_COLOR;
               end
               S_COLOR: begin
                  acc_q <= acc_nxt;
                  col_q <= col_q + COLOR_W'(1);
                  if (col_last) begin
                     score_exact   <= exact_q;
                     score_partial <= acc_nxt - exact_q;
                     score_valid   <= 1'b1;
                     state         <= S_REPORT;
                  end
               end
               S_REPORT: begin
                  if (exact_q == SC_W'(NUM_PEGS))
                     state <= S_WON;
                  else if (turn == TURN_W'(MAX_TURNS - 1))
                     state <= S_LOST;
                  else begin
                     turn  <= turn + TURN_W'(1);
                     state <= S_ENTRY;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef MASTERMIND_HISTORY_EN
   logic [CODE_W-1:0] hist_g [MAX_TURNS];
   logic [SC_W-1:0]   hist_e [MAX_TURNS];
   logic [SC_W-1:0]   hist_p [MAX_TURNS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < MAX_TURNS; t++) begin
            hist_g[t] <= '0;
            hist_e[t] <= '0;
            hist_p[t] <= '0;
         end
      end else if (load_ok) begin
         for (int t = 0; t < MAX_TURNS; t++) begin
            hist_g[t] <= '0;
            hist_e[t] <= '0;
            hist_p[t] <= '0;
         end
      end else if (report_wr) begin
         hist_g[turn] <= guess_out;
         hist_e[turn] <= exact_q;
         hist_p[turn] <= acc_nxt - exact_q;
      end
   end

   always_comb begin
      hist_guess   = '0;
      hist_exact   = '0;
      hist_partial = '0;
      if (int'(hist_idx) < MAX_TURNS) begin
         hist_guess   = hist_g[hist_idx];
         hist_exact   = hist_e[hist_idx];
         hist_partial = hist_p[hist_idx];
      end
   end
`endif

endmodule

// File: tb/tb_mastermind_core.sv
// tb_mastermind_core: directed game scenarios checked every cycle
// against a pairing-based game model plus literal expectations.
module tb_mastermind_core;

   localparam int NP   = 4;
   localparam int MT   = 8;
   localparam int NCOL = 8;

   localparam logic [5:0] B_NONE  = 6'b000000;
   localparam logic [5:0] B_DOWN  = 6'b000001;
   localparam logic [5:0] B_UP    = 6'b000010;
   localparam logic [5:0] B_RIGHT = 6'b000100;
   localparam logic [5:0] B_LEFT  = 6'b001000;
   localparam logic [5:0] B_SEL   = 6'b010000;
   localparam logic [5:0] B_LOAD  = 6'b100000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [11:0] code_in = '0;
   logic        code_load = 1'b0;
   logic        btn_left = 1'b0;
   logic        btn_right = 1'b0;
   logic        btn_up = 1'b0;
   logic        btn_down = 1'b0;
   logic        btn_select = 1'b0;
   logic [11:0] guess_out;
   logic [1:0]  cursor;
   logic [2:0]  turn;
   logic [2:0]  score_exact;
   logic [2:0]  score_partial;
   logic        score_valid;
   logic        busy;
   logic        game_over;
   logic        win;
`ifdef MASTERMIND_HISTORY_EN
   logic [2:0]  hist_idx = '0;
   logic [11:0] hist_guess;
   logic [2:0]  hist_exact;
   logic [2:0]  hist_partial;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mastermind_core dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .code_in       (code_in),
      .code_load     (code_load),
      .btn_left      (btn_left),
      .btn_right     (btn_right),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .btn_select    (btn_select),
      .guess_out     (guess_out),
      .cursor        (cursor),
      .turn          (turn),
      .score_exact   (score_exact),
      .score_partial (score_partial),
      .score_valid   (score_valid),
      .busy          (busy),
      .game_over     (game_over),
`ifdef MASTERMIND_HISTORY_EN
      .hist_idx      (hist_idx),
      .hist_guess    (hist_guess),
      .hist_exact    (hist_exact),
      .hist_partial  (hist_partial),
`endif
      .win           (win)
   );

   function automatic logic [11:0] pk(input int a, input int b,
                                      input int c, input int d);
      pk = {d[2:0], c[2:0], b[2:0], a[2:0]};
   endfunction

   // Classic pairing: take exact matches first, then pair leftovers by color
   function automatic void judge(input int c[4], input int g[4],
                                 output int e, output int p);
      bit uc[4];
      bit ug[4];
      bit hit;
      e = 0;
      p = 0;
      for (int i = 0; i < 4; i++) begin
         uc[i] = 1'b0;
         ug[i] = 1'b0;
      end
      for (int i = 0; i < 4; i++)
         if (c[i] == g[i]) begin
            e++;
            uc[i] = 1'b1;
            ug[i] = 1'b1;
         end
      for (int i = 0; i < 4; i++) begin
         hit = 1'b0;
         if (!ug[i])
            for (int j = 0; j < 4; j++)
               if (!hit && !uc[j] && c[j] == g[i]) begin
                  p++;
                  uc[j] = 1'b1;
                  hit = 1'b1;
               end
      end
   endfunction

   typedef enum int {PH_IDLE, PH_ENTRY, PH_BUSY, PH_REPORT,
                     PH_WON, PH_LOST} ph_t;

   ph_t         m_ph;
   int          m_code[4];
   int          m_guess[4];
   int          m_cur, m_turn, m_ex, m_pa, m_pe, m_pp, m_left;
   bit          m_valid;
   logic [11:0] m_hg[8];
   int          m_he[8];
   int          m_hp[8];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = PH_IDLE;
         m_cur = 0; m_turn = 0; m_ex = 0; m_pa = 0;
         m_left = 0; m_valid = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m_code[i] = 0;
            m_guess[i] = 0;
         end
         for (int t = 0; t < MT; t++) begin
            m_hg[t] = '0; m_he[t] = 0; m_hp[t] = 0;
         end
      end else begin
         m_valid = 1'b0;
         if (code_load && m_ph != PH_BUSY) begin
            for (int i = 0; i < 4; i++) begin
               m_code[i] = int'(code_in[i*3 +: 3]);
               m_guess[i] = 0;
            end
            m_cur = 0; m_turn = 0; m_ex = 0; m_pa = 0;
            for (int t = 0; t < MT; t++) begin
               m_hg[t] = '0; m_he[t] = 0; m_hp[t] = 0;
            end
            m_ph = PH_ENTRY;
         end else begin
            case (m_ph)
               PH_ENTRY:
                  if (btn_select) begin
                     judge(m_code, m_guess, m_pe, m_pp);
                     m_left = NCOL + 1;
                     m_ph = PH_BUSY;
                  end else if (btn_left)
                     m_cur = (m_cur + NP - 1) % NP;
                  else if (btn_right)
                     m_cur = (m_cur + 1) % NP;
                  else if (btn_up)
                     m_guess[m_cur] = (m_guess[m_cur] + 1) % NCOL;
                  else if (btn_down)
                     m_guess[m_cur] = (m_guess[m_cur] + NCOL - 1) % NCOL;
               PH_BUSY: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_ex = m_pe;
                     m_pa = m_pp;
                     m_valid = 1'b1;
                     m_hg[m_turn] = pk(m_guess[0], m_guess[1],
                                       m_guess[2], m_guess[3]);
                     m_he[m_turn] = m_pe;
                     m_hp[m_turn] = m_pp;
                     m_ph = PH_REPORT;
                  end
               end
               PH_REPORT:
                  if (m_ex == NP) m_ph = PH_WON;
                  else if (m_turn == MT - 1) m_ph = PH_LOST;
                  else begin
                     m_turn++;
                     m_ph = PH_ENTRY;
                  end
               default: ;
            endcase
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc.guess", int'(guess_out),
          int'(pk(m_guess[0], m_guess[1], m_guess[2], m_guess[3])));
      chk("cyc.cursor", int'(cursor), m_cur);
      chk("cyc.turn", int'(turn), m_turn);
      chk("cyc.exact", int'(score_exact), m_ex);
      chk("cyc.partial", int'(score_partial), m_pa);
      chk("cyc.valid", int'(score_valid), int'(m_valid));
      chk("cyc.busy", int'(busy), int'(m_ph == PH_BUSY));
      chk("cyc.over", int'(game_over),
          int'(m_ph == PH_WON || m_ph == PH_LOST));
      chk("cyc.win", int'(win), int'(m_ph == PH_WON));
`ifdef MASTERMIND_HISTORY_EN
      chk("cyc.hguess", int'(hist_guess), int'(m_hg[int'(hist_idx)]));
      chk("cyc.hexact", int'(hist_exact), m_he[int'(hist_idx)]);
      chk("cyc.hpart", int'(hist_partial), m_hp[int'(hist_idx)]);
`endif
   end

   task automatic step(input logic [5:0] b);
      {code_load, btn_select, btn_left, btn_right, btn_up, btn_down} = b;
      @(posedge clk);
      #1;
      {code_load, btn_select, btn_left, btn_right, btn_up, btn_down} = '0;
   endtask

   task automatic load(input logic [11:0] c);
      code_in = c;
      step(B_LOAD);
   endtask

   // Assumes the cursor starts on peg 0; four rights bring it back
   task automatic set_guess(input int a, input int b, input int c, input int d);
      int tg[4];
      int n;
      tg = '{a, b, c, d};
      for (int p = 0; p < 4; p++) begin
         n = (tg[p] - m_guess[p] + NCOL) % NCOL;
         repeat (n) step(B_UP);
         step(B_RIGHT);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!score_valid && n < 40) begin
         step(B_NONE);
         n++;
      end
      if (!score_valid)
         chk("timeout.valid", int'(score_valid), 1);
   endtask

   task automatic play(input int a, input int b, input int c, input int d);
      int n;
      set_guess(a, b, c, d);
      step(B_SEL);
      wait_valid(n);
      step(B_NONE);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int sv;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.guess", int'(guess_out), 0);
      chk("rst.valid", int'(score_valid), 0);
      chk("rst.busy", int'(busy), 0);
      chk("rst.over", int'(game_over), 0);
      chk("rst.win", int'(win), 0);
      rst_n = 1'b1;
      step(B_UP);
      step(B_RIGHT);
      step(B_SEL);
      chk("idle.guess", int'(guess_out), 0);
      chk("idle.cursor", int'(cursor), 0);
      chk("idle.busy", int'(busy), 0);

      load(pk(3, 5, 1, 6));
      set_guess(3, 5, 1, 6);
      step(B_SEL);
      wait_valid(n);
      chk("win.latency", n + 1, 10);
      chk("win.exact", int'(score_exact), 4);
      chk("win.partial", int'(score_partial), 0);
      step(B_NONE);
      chk("win.win", int'(win), 1);
      chk("win.over", int'(game_over), 1);
      step(B_UP);
      step(B_SEL);
      chk("won.hold", int'(guess_out), int'(pk(3, 5, 1, 6)));

      load(pk(1, 1, 2, 2));
      set_guess(1, 2, 1, 3);
      step(B_SEL);
      step(B_NONE);
      code_in = pk(7, 7, 7, 7);
      step(B_LOAD);
      wait_valid(n);
      chk("dup.exact", int'(score_exact), 1);
      chk("dup.partial", int'(score_partial), 2);
      step(B_NONE);
      chk("dup.turn", int'(turn), 1);
      chk("dup.over", int'(game_over), 0);
      chk("dup.retain", int'(guess_out), int'(pk(1, 2, 1, 3)));

      load(pk(0, 0, 0, 0));
      step(B_LEFT);
      chk("edit.lwrap", int'(cursor), 3);
      step(B_DOWN);
      chk("edit.dwrap", int'(guess_out), int'(pk(0, 0, 0, 7)));
      step(B_UP);
      chk("edit.uwrap", int'(guess_out), 0);
      step(B_LEFT | B_RIGHT);
      chk("edit.prio_lr", int'(cursor), 2);
      step(B_UP | B_DOWN);
      chk("edit.prio_ud", int'(guess_out), int'(pk(0, 0, 1, 0)));
      step(B_SEL | B_UP);
      chk("edit.sel_busy", int'(busy), 1);
      chk("edit.sel_peg", int'(guess_out), int'(pk(0, 0, 1, 0)));
      wait_valid(n);
      chk("edit.exact", int'(score_exact), 3);
      step(B_NONE);

      load(pk(0, 0, 0, 0));
      set_guess(7, 7, 7, 7);
      for (int t = 0; t < MT; t++) begin
         step(B_SEL);
         wait_valid(n);
         step(B_NONE);
      end
      chk("lost.over", int'(game_over), 1);
      chk("lost.win", int'(win), 0);
      chk("lost.turn", int'(turn), 7);
      step(B_UP);
      step(B_LEFT);
      step(B_SEL);
      chk("lost.hold", int'(guess_out), int'(pk(7, 7, 7, 7)));
      chk("lost.busy", int'(busy), 0);

      load(pk(1, 2, 3, 4));
      set_guess(4, 3, 2, 1);
      step(B_SEL);
      repeat (3) step(B_NONE);
      chk("mid.busy", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid.guess", int'(guess_out), 0);
      chk("mid.turn", int'(turn), 0);
      chk("mid.busy0", int'(busy), 0);
      #3 rst_n = 1'b1;
      sv = 0;
      repeat (15) begin
         step(B_NONE);
         sv += int'(score_valid);
      end
      chk("mid.novalid", sv, 0);
      step(B_UP);
      step(B_RIGHT);
      chk("mid.idle", int'(guess_out), 0);

`ifdef MASTERMIND_HISTORY_EN
      load(pk(1, 1, 2, 2));
      play(0, 0, 0, 0);
      play(1, 2, 1, 3);
      play(2, 2, 1, 1);
      hist_idx = 3'd1;
      #1;
      chk("hist.guess", int'(hist_guess), int'(pk(1, 2, 1, 3)));
      chk("hist.exact", int'(hist_exact), 1);
      chk("hist.partial", int'(hist_partial), 2);
      hist_idx = 3'd2;
      #1;
      chk("hist.partial2", int'(hist_partial), 4);
      code_in = pk(0, 0, 0, 0);
      step(B_LOAD);
      chk("hist.clear", int'(hist_guess), 0);
      chk("hist.clearp", int'(hist_partial), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
